addsub_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one `addSubComd` N-bit add/subtract unit between two requesters.
- Each requester presents an operation (a, b, sub) on a valid/ready handshake.
- The arbiter grants one requester, registers its operands, drives the shared unit, and returns a registered result tagged with the requester id over a valid/ready response channel.
- It sits between the register-file/control side and the combinational add/sub datapath.

---
 rtl/addsub_pkg.sv | 31 +++
 rtl/addsub_arbiter_if.sv | 45 ++++
 rtl/addSubComd.sv | 20 ++
 rtl/addsub_arbiter.sv | 124 ++++++++++++
 tb/tb_addsub_arbiter.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/addsub_pkg.sv
// ---------------------------------------------------------------------------
// addsub_pkg
// Shared types for the add/sub arbiter slice.
//   ADDSUB_W    : default operand/result width
//   state_t     : sequencer states (IDLE, EXEC, RESP)
//   addsub_op_t : latched operation {a, b, sub, id}
//   signed_ovf  : two's-complement overflow from the three MSBs
// ---------------------------------------------------------------------------
package addsub_pkg;

   parameter int ADDSUB_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic [ADDSUB_W-1:0] a;
      logic [ADDSUB_W-1:0] b;
      logic                sub;
      logic                id;
   } addsub_op_t;

   // Overflow when both effective addends share a sign and the sum's sign differs.
   function automatic logic signed_ovf(input logic a_msb, input logic bp_msb, input logic s_msb);
      return (a_msb == bp_msb) && (s_msb != a_msb);
   endfunction

endpackage

// File: rtl/addsub_arbiter_if.sv
// ---------------------------------------------------------------------------
// addsub_arbiter_if
// Two request channels (valid/ready + a, b, sub) and one response channel
// (valid/ready + id, s, cout, ovf).
//   master : requesters and response consumer side
//   slave  : arbiter side
// ---------------------------------------------------------------------------
interface addsub_arbiter_if
   import addsub_pkg::*;
#(
   parameter int N = ADDSUB_W
);
   logic         req0_valid;
   logic         req0_ready;
   logic [N-1:0] req0_a;
   logic [N-1:0] req0_b;
   logic         req0_sub;
   logic         req1_valid;
   logic         req1_ready;
   logic [N-1:0] req1_a;
   logic [N-1:0] req1_b;
   logic         req1_sub;
   logic         resp_valid;
   logic         resp_ready;
   logic         resp_id;
   logic [N-1:0] resp_s;
   logic         resp_cout;
   logic         resp_ovf;

   modport master (
      output req0_valid, req0_a, req0_b, req0_sub,
      output req1_valid, req1_a, req1_b, req1_sub,
      output resp_ready,
      input  req0_ready, req1_ready,
      input  resp_valid, resp_id, resp_s, resp_cout, resp_ovf
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_sub,
      input  req1_valid, req1_a, req1_b, req1_sub,
      input  resp_ready,
      output req0_ready, req1_ready,
      output resp_valid, resp_id, resp_s, resp_cout, resp_ovf
   );
endinterface

// File: rtl/addSubComd.sv
// ---------------------------------------------------------------------------
// addSubComd
// Combinational N-bit adder/subtractor: s = a + b (sub=0) or a + ~b + 1 (sub=1).
//   a, b : operands      sub  : 0 add, 1 subtract
//   s    : result mod 2^N cout : carry out of the MSB (1 = no borrow on sub)
// ---------------------------------------------------------------------------
module addSubComd #(
   parameter int N = 4
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         sub,
   output logic [N-1:0] s,
   output logic         cout
);
   logic [N-1:0] bx_s;

   assign bx_s      = b ^ {N{sub}};
   assign {cout, s} = {1'b0, a} + {1'b0, bx_s} + {{N{1'b0}}, sub};
endmodule

// File: rtl/addsub_arbiter.sv
// ---------------------------------------------------------------------------
// addsub_arbiter
// Round-robin arbiter/sequencer sharing one addSubComd between two requesters.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : slave side of addsub_arbiter_if (two request channels, one
//         response channel; readies are the only combinational outputs)
// ---------------------------------------------------------------------------
module addsub_arbiter
   import addsub_pkg::*;
#(
   parameter int N = ADDSUB_W
) (
   input  logic              clk,
   input  logic              rst,
   addsub_arbiter_if.slave   bus
);
   state_t       state_r;
   state_t       state_nxt_s;
   logic         last_grant_r;
   addsub_op_t   op_r;
   logic         gnt_s;
   logic         gnt_id_s;
   logic [N-1:0] sum_s;
   logic         cout_s;
   logic [N-1:0] bp_s;
   logic         resp_valid_r;
   logic         resp_id_r;
   logic [N-1:0] resp_s_r;
   logic         resp_cout_r;
   logic         resp_ovf_r;

   addSubComd #(.N(N)) u_addsub (
      .a    (op_r.a),
      .b    (op_r.b),
      .sub  (op_r.sub),
      .s    (sum_s),
      .cout (cout_s)
   );

   // Effective second addend, used only for the overflow flag.
   assign bp_s = op_r.b ^ {N{op_r.sub}};

   // Grant selection and next-state decode.
   always_comb begin
      gnt_s       = 1'b0;
      gnt_id_s    = 1'b0;
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.req0_valid && bus.req1_valid) begin
               // Tie: whoever was not served last wins.
               gnt_s    = 1'b1;
               gnt_id_s = ~last_grant_r;
            end else if (bus.req0_valid) begin
               gnt_s    = 1'b1;
               gnt_id_s = 1'b0;
            end else if (bus.req1_valid) begin
               gnt_s    = 1'b1;
               gnt_id_s = 1'b1;
            end else begin
               gnt_s    = 1'b0;
               gnt_id_s = 1'b0;
            end
            if (gnt_s) begin
               state_nxt_s = EXEC;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         EXEC: state_nxt_s = RESP;
         RESP: begin
            if (bus.resp_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = RESP;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Readies are suppressed while reset is asserted so nothing is accepted.
   assign bus.req0_ready = gnt_s && !gnt_id_s && !rst;
   assign bus.req1_ready = gnt_s &&  gnt_id_s && !rst;

   // State, operand latch, round-robin pointer and registered response.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         last_grant_r <= 1'b1;
         op_r         <= '0;
         resp_valid_r <= 1'b0;
         resp_id_r    <= 1'b0;
         resp_s_r     <= '0;
         resp_cout_r  <= 1'b0;
         resp_ovf_r   <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         if (gnt_s) begin
            op_r.a       <= gnt_id_s ? bus.req1_a   : bus.req0_a;
            op_r.b       <= gnt_id_s ? bus.req1_b   : bus.req0_b;
            op_r.sub     <= gnt_id_s ? bus.req1_sub : bus.req0_sub;
            op_r.id      <= gnt_id_s;
            last_grant_r <= gnt_id_s;
         end
         if (state_r == EXEC) begin
            resp_valid_r <= 1'b1;
            resp_id_r    <= op_r.id;
            resp_s_r     <= sum_s;
            resp_cout_r  <= cout_s;
            resp_ovf_r   <= signed_ovf(op_r.a[N-1], bp_s[N-1], sum_s[N-1]);
         end else if ((state_r == RESP) && bus.resp_ready) begin
            resp_valid_r <= 1'b0;
         end
      end
   end

   assign bus.resp_valid = resp_valid_r;
   assign bus.resp_id    = resp_id_r;
   assign bus.resp_s     = resp_s_r;
   assign bus.resp_cout  = resp_cout_r;
   assign bus.resp_ovf   = resp_ovf_r;
endmodule

// File: tb/tb_addsub_arbiter.sv
// ---------------------------------------------------------------------------
// tb_addsub_arbiter
// Directed self-checking bench for addsub_arbiter (N = 4).
// ---------------------------------------------------------------------------
module tb_addsub_arbiter;
   import addsub_pkg::*;

   localparam int N = 4;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   ids[4];
   int   k;

   always #5 clk = ~clk;

   addsub_arbiter_if #(.N(N)) bus ();

   addsub_arbiter #(.N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input bit id, input logic v, input logic [3:0] a,
                          input logic [3:0] b, input logic sub);
      if (id) begin
         bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_sub = sub;
      end else begin
         bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_sub = sub;
      end
   endtask

   // One isolated operation starting in IDLE; expects acceptance in the first cycle.
   task automatic run_op(input string tag, input bit id, input logic [3:0] a, input logic [3:0] b,
                         input logic sub, input logic [3:0] es, input logic ec, input logic eo);
      set_req(id, 1'b1, a, b, sub);
      #1;
      check_eq({tag, "_rdy"},   id ? bus.req1_ready : bus.req0_ready, 1);
      check_eq({tag, "_other"}, id ? bus.req0_ready : bus.req1_ready, 0);
      tick();
      set_req(id, 1'b0, 4'h0, 4'h0, 1'b0);
      #1;
      check_eq({tag, "_exec_v"}, bus.resp_valid, 0);
      tick();
      check_eq({tag, "_v"},    bus.resp_valid, 1);
      check_eq({tag, "_id"},   bus.resp_id, id);
      check_eq({tag, "_s"},    bus.resp_s, es);
      check_eq({tag, "_cout"}, bus.resp_cout, ec);
      check_eq({tag, "_ovf"},  bus.resp_ovf, eo);
      bus.resp_ready = 1'b1;
      tick();
      bus.resp_ready = 1'b0;
      #1;
      check_eq({tag, "_done"}, bus.resp_valid, 0);
   endtask

   initial begin
      rst = 1'b1;
      set_req(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
      set_req(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
      bus.resp_ready = 1'b0;
      tick();
      tick();
      check_eq("rst_valid", bus.resp_valid, 0);
      check_eq("rst_id",    bus.resp_id, 0);
      check_eq("rst_s",     bus.resp_s, 0);
      check_eq("rst_cout",  bus.resp_cout, 0);
      check_eq("rst_ovf",   bus.resp_ovf, 0);
      check_eq("rst_rdy0",  bus.req0_ready, 0);
      check_eq("rst_rdy1",  bus.req1_ready, 0);
      rst = 1'b0;

      run_op("add1",       1'b0, 4'b1000, 4'b0001, 1'b0, 4'b1001, 1'b0, 1'b0);
      run_op("sub_borrow", 1'b1, 4'b0000, 4'b0001, 1'b1, 4'b1111, 1'b0, 1'b0);
      run_op("add_ovf",    1'b0, 4'b0100, 4'b0100, 1'b0, 4'b1000, 1'b0, 1'b1);
      run_op("sub_ovf",    1'b1, 4'b1000, 4'b0001, 1'b1, 4'b0111, 1'b1, 1'b1);
      run_op("add_noovf",  1'b1, 4'b1010, 4'b0101, 1'b0, 4'b1111, 1'b0, 1'b0);

      // Fairness: last grant was 1, so the tie sequence starts with 0.
      set_req(1'b0, 1'b1, 4'h1, 4'h1, 1'b0);
      set_req(1'b1, 1'b1, 4'h2, 4'h2, 1'b0);
      bus.resp_ready = 1'b1;
      #1;
      k = 0;
      for (int c = 0; c < 12; c++) begin
         check_eq($sformatf("rr_rdy0_c%0d", c), bus.req0_ready, (c % 6) == 0);
         check_eq($sformatf("rr_rdy1_c%0d", c), bus.req1_ready, (c % 6) == 3);
         if (bus.resp_valid && (k < 4)) begin
            ids[k] = int'(bus.resp_id);
            k++;
         end
         tick();
      end
      set_req(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
      set_req(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
      bus.resp_ready = 1'b0;
      check_eq("rr_count", k, 4);
      if (k == 4) begin
         check_eq("rr_id0", ids[0], 0);
         check_eq("rr_id1", ids[1], 1);
         check_eq("rr_id2", ids[2], 0);
         check_eq("rr_id3", ids[3], 1);
      end else begin
         check_eq("rr_ids_present", 0, 1);
      end

      // Backpressure: response held 5 cycles while req1 waits.
      set_req(1'b0, 1'b1, 4'b0011, 4'b0010, 1'b0);
      #1;
      check_eq("bp_rdy0", bus.req0_ready, 1);
      tick();
      set_req(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
      tick();
      set_req(1'b1, 1'b1, 4'b0001, 4'b0001, 1'b0);
      #1;
      for (int c = 0; c < 5; c++) begin
         check_eq($sformatf("bp_v_c%0d", c),    bus.resp_valid, 1);
         check_eq($sformatf("bp_s_c%0d", c),    bus.resp_s, 4'b0101);
         check_eq($sformatf("bp_id_c%0d", c),   bus.resp_id, 0);
         check_eq($sformatf("bp_rdy0_c%0d", c), bus.req0_ready, 0);
         check_eq($sformatf("bp_rdy1_c%0d", c), bus.req1_ready, 0);
         tick();
      end
      bus.resp_ready = 1'b1;
      tick();
      bus.resp_ready = 1'b0;
      #1;
      check_eq("bp_after_v",    bus.resp_valid, 0);
      check_eq("bp_after_rdy1", bus.req1_ready, 1);
      tick();
      set_req(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
      tick();
      check_eq("bp2_id", bus.resp_id, 1);
      check_eq("bp2_s",  bus.resp_s, 4'b0010);
      bus.resp_ready = 1'b1;
      tick();
      bus.resp_ready = 1'b0;

      // Reset during EXEC discards the op and restores requester 0 priority.
      set_req(1'b0, 1'b1, 4'b0111, 4'b0001, 1'b0);
      #1;
      check_eq("mid_rdy0", bus.req0_ready, 1);
      tick();
      set_req(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         check_eq($sformatf("mid_nov_c%0d", c), bus.resp_valid, 0);
         tick();
      end
      set_req(1'b0, 1'b1, 4'b0101, 4'b0001, 1'b0);
      set_req(1'b1, 1'b1, 4'b0110, 4'b0001, 1'b0);
      #1;
      check_eq("post_rdy0", bus.req0_ready, 1);
      check_eq("post_rdy1", bus.req1_ready, 0);
      tick();
      set_req(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
      set_req(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
      tick();
      check_eq("post_v",  bus.resp_valid, 1);
      check_eq("post_id", bus.resp_id, 0);
      check_eq("post_s",  bus.resp_s, 4'b0110);
      bus.resp_ready = 1'b1;
      tick();
      bus.resp_ready = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
